ifu_burst_prefetch: RTL

//  Parametrised instruction fetch front-end: AXI4 read master issuing INCR bursts over sequential
//  PCs and filling an in-order prefetch FIFO that feeds the IDU via valid/ready. Supports

---
 rtl/ifu_pkg.sv | 39 +++
 rtl/ifu_fifo.sv | 89 ++++++++
 rtl/ifu_burst_prefetch.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the burst-prefetching instruction fetch unit.
//   - reset PC constants for the NPC and SoC builds
//   - AXI4 encodings used by the fetch master (INCR burst, 4-byte beats, OKAY)
//   - fetch_entry_t: one prefetched instruction {pc, inst, err}
//   - ifu_state_t:   fetch FSM states
//   - burst_beats(): beats left until the next BURST_LEN*4-byte boundary
// -----------------------------------------------------------------------------
package ifu_pkg;

    localparam logic [31:0] RESET_PC_NPC   = 32'h8000_0000;
    localparam logic [31:0] RESET_PC_SOC   = 32'h3000_0000;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0]  RESP_OKAY      = 2'b00;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        DRAIN
    } ifu_state_t;

    // A burst starting at pc stops at the next aligned burst boundary, so a
    // burst never crosses a 4KB page either.
    function automatic int unsigned burst_beats(input logic [31:0] pc,
                                                input int unsigned burst_len);
        return burst_len - ((pc >> 2) & (burst_len - 1));
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// -----------------------------------------------------------------------------
// ifu_fifo
// In-order prefetch FIFO of fetch_entry_t. Head is read combinationally from
// the storage array, so an entry is visible the cycle after it is pushed.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        drop all entries this edge (wins over push/pop)
//   push, push_data   write one entry at the tail
//   pop          remove the head entry (ignored when empty)
//   head         current head entry
//   count        number of stored entries (one extra bit so DEPTH fits)
//   empty        count == 0
// -----------------------------------------------------------------------------
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is not reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

`ifndef SYNTHESIS
    // Space is reserved before a burst is requested, so a push into a full
    // FIFO means the reservation bookkeeping is broken.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && full));
`endif

endmodule

// File: rtl/ifu_burst_prefetch.sv
// -----------------------------------------------------------------------------
// ifu_burst_prefetch
// Instruction fetch front-end: AXI4 read master issuing aligned INCR bursts
// over sequential PCs, filling an in-order prefetch FIFO that feeds the IDU.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   redirect_valid/redirect_pc flush and restart fetch at a new PC
//   out_valid/out_ready        FIFO head handshake to the IDU
//   out_pc/out_inst/out_err    head entry (err = beat had rresp != OKAY)
//   arvalid/arready, araddr, arid, arlen, arsize, arburst   AXI AR channel
//   rvalid/rready, rdata, rresp, rlast, rid                 AXI R channel
// -----------------------------------------------------------------------------
module ifu_burst_prefetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_NPC,
    parameter int          BURST_LEN  = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ifu_state_t       state_reg, state_next;
    logic [31:0]      fetch_pc_reg, fetch_pc_next;   // next PC to request
    logic [31:0]      araddr_reg, araddr_next;
    logic [7:0]       arlen_reg, arlen_next;
    logic [31:0]      beat_pc_reg, beat_pc_next;     // PC of the next R beat
    logic [CNT_W-1:0] reserved_reg, reserved_next;   // beats requested, not yet pushed
    logic             halted_reg, halted_next;
    logic             err_seen_reg, err_seen_next;
    logic             ar_killed_reg, ar_killed_next; // redirect arrived while in AR

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;

    logic [CNT_W-1:0] beats_now;
    logic [CNT_W-1:0] free_slots;
    logic             beat_err;

    // Single ID and at most one outstanding burst, so rid carries no information.
    logic unused_rid;
    assign unused_rid = ^rid;

    assign beats_now  = CNT_W'(burst_beats(fetch_pc_reg, BURST_LEN));
    assign free_slots = CNT_W'(FIFO_DEPTH) - fifo_count - reserved_reg;
    assign beat_err   = (rresp != RESP_OKAY);

    // A beat coinciding with a redirect belongs to the old stream: drop it.
    assign fifo_push  = (state_reg == R) && rvalid && !redirect_valid;
    assign fifo_pop   = out_valid && out_ready && !redirect_valid;
    assign push_entry = '{pc: beat_pc_reg, inst: rdata, err: beat_err};

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        araddr_next    = araddr_reg;
        arlen_next     = arlen_reg;
        beat_pc_next   = beat_pc_reg;
        reserved_next  = reserved_reg;
        halted_next    = halted_reg;
        err_seen_next  = err_seen_reg;
        ar_killed_next = ar_killed_reg;

        unique case (state_reg)
            IDLE: begin
                if (!redirect_valid && !halted_reg && free_slots >= beats_now) begin
                    state_next     = AR;
                    araddr_next    = fetch_pc_reg;
                    arlen_next     = 8'(beats_now - 1'b1);
                    beat_pc_next   = fetch_pc_reg;
                    fetch_pc_next  = fetch_pc_reg + (32'(beats_now) << 2);
                    reserved_next  = beats_now;
                    err_seen_next  = 1'b0;
                    ar_killed_next = 1'b0;
                end
            end
            AR: begin
                // The request cannot be withdrawn once valid; remember to drain it.
                if (redirect_valid) begin
                    ar_killed_next = 1'b1;
                end
                if (arready) begin
                    state_next = (ar_killed_reg || redirect_valid) ? DRAIN : R;
                end
            end
            R: begin
                if (rvalid && !redirect_valid) begin
                    beat_pc_next  = beat_pc_reg + 32'd4;
                    reserved_next = reserved_reg - 1'b1;
                    if (beat_err) begin
                        err_seen_next = 1'b1;
                    end
                end
                if (rvalid && rlast) begin
                    state_next    = IDLE;
                    reserved_next = '0;
                    halted_next   = err_seen_reg || beat_err;
                end else if (redirect_valid) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (rvalid && rlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Redirect overrides everything; the latest one wins.
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            halted_next   = 1'b0;
            err_seen_next = 1'b0;
            reserved_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            fetch_pc_reg  <= RESET_PC;
            araddr_reg    <= '0;
            arlen_reg     <= '0;
            beat_pc_reg   <= '0;
            reserved_reg  <= '0;
            halted_reg    <= 1'b0;
            err_seen_reg  <= 1'b0;
            ar_killed_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            araddr_reg    <= araddr_next;
            arlen_reg     <= arlen_next;
            beat_pc_reg   <= beat_pc_next;
            reserved_reg  <= reserved_next;
            halted_reg    <= halted_next;
            err_seen_reg  <= err_seen_next;
            ar_killed_reg <= ar_killed_next;
        end
    end

    assign arvalid   = (state_reg == AR);
    assign araddr    = araddr_reg;
    assign arlen     = arlen_reg;
    assign arid      = AXI_ID;
    assign arsize    = AXI_SIZE_4B;
    assign arburst   = AXI_BURST_INCR;
    assign rready    = (state_reg == R) || (state_reg == DRAIN);

    assign out_valid = !fifo_empty;
    assign out_pc    = fifo_head.pc;
    assign out_inst  = fifo_head.inst;
    assign out_err   = fifo_head.err;

endmodule
